// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the fabric and the register file.
// Master drives the request, slave returns data and status.
interface apb_slave_regfile_if #(
  parameter int AW = 20,
  parameter int DW = 32
);
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW/8-1:0] PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA,
    output PSTRB,
    input  PRDATA,
    input  PREADY,
    input  PSLVERR
  );

  modport slave (
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
    input  PSTRB,
    output PRDATA,
    output PREADY,
    output PSLVERR
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB register file: RW config words, STATUS word,
// wait states, byte strobes and a deferred start pulse.
module apb_slave_regfile #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int NUM_REGS        = 4,
  parameter int WAIT_STATES     = 0
) (
  input  logic clk,
  input  logic rst,
  apb_slave_regfile_if.slave apb,
  input  logic core_busy,
  input  logic [AMBA_WORD-3:0] core_status,
  output logic [NUM_REGS*AMBA_WORD-1:0] regs,
  output logic start
);

  localparam int NB = AMBA_WORD / 8;
  localparam logic [5:0] STATUS_IDX = 6'(NUM_REGS);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  logic [AMBA_WORD-1:0] regs_q [NUM_REGS];
  logic [AMBA_WORD-1:0] regs_d [NUM_REGS];
  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;
  logic       start_q;
  logic       start_d;
  logic       pend_q;
  logic       pend_d;

  logic [7:0] offset;
  logic [5:0] idx;
  logic       access;
  logic       ready;
  logic       is_ctrl;
  logic       is_status;
  logic       err;
  logic       wr_ok;
  logic       ctrl_commit;
  logic [AMBA_WORD-1:0] rd_val;
  logic       unused_paddr;

  assign offset = apb.PADDR[7:0];
  assign idx    = offset[7:2];

  if (AMBA_ADDR_WIDTH > 8) begin : g_hi
    assign unused_paddr = ^apb.PADDR[AMBA_ADDR_WIDTH-1:8];
  end else begin : g_no_hi
    assign unused_paddr = 1'b0;
  end

  assign access    = apb.PSEL & apb.PENABLE;
  assign ready     = access & (wait_cnt_q == WAIT_LAST);
  assign is_ctrl   = (idx == 6'd0);
  assign is_status = (idx == STATUS_IDX);

  // Error classification for the addressed transfer
  always_comb begin
    err = 1'b0;
    if (offset[1:0] != 2'b00) err = 1'b1;
    if (idx > STATUS_IDX) err = 1'b1;
    if (apb.PWRITE & is_status) err = 1'b1;
    if (apb.PWRITE & is_ctrl & pend_q) err = 1'b1;
  end

  assign wr_ok = ready & apb.PWRITE & ~err;
  assign ctrl_commit = wr_ok & is_ctrl & (|apb.PSTRB);

  // Wait-state counter: clears when idle or on completion
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    unique case (1'b1)
      !access: wait_cnt_d = '0;
      ready:   wait_cnt_d = '0;
      default: wait_cnt_d = wait_cnt_q + 4'd1;
    endcase
  end

  // Byte-strobed register update on a clean write
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && idx == 6'(i)) begin
        for (int b = 0; b < NB; b++) begin
          if (apb.PSTRB[b]) begin
            regs_d[i][8*b +: 8] = apb.PWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  // Start handshake: fire now or park until core idles
  always_comb begin
    start_d = ~core_busy & (ctrl_commit | pend_q);
    pend_d  = core_busy & (ctrl_commit | pend_q);
  end

  // Read mux over RW registers and STATUS
  always_comb begin
    rd_val = '0;
    if (is_status) begin
      rd_val = {core_status, pend_q, core_busy};
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 6'(i)) rd_val = regs_q[i];
    end
  end

  // Bus response
  always_comb begin
    apb.PREADY  = ready;
    apb.PSLVERR = ready & err;
    apb.PRDATA  = '0;
    if (ready & ~apb.PWRITE & ~err) begin
      apb.PRDATA = rd_val;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wait_cnt_q <= '0;
      start_q    <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wait_cnt_q <= wait_cnt_d;
      start_q    <= start_d;
      pend_q     <= pend_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[g*AMBA_WORD +: AMBA_WORD] = regs_q[g];
  end

  assign start = start_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized bench for apb_slave_regfile against a
// transaction-level register model.
module tb_apb_slave_regfile;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam int NR = 4;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst;
  logic core_busy;
  logic [DW-3:0] core_status;
  logic [NR*DW-1:0] regs;
  logic start;

  always #5 clk = ~clk;

  apb_slave_regfile_if #(.AW(AW), .DW(DW)) apb ();

  apb_slave_regfile #(
    .AMBA_WORD(DW),
    .AMBA_ADDR_WIDTH(AW),
    .NUM_REGS(NR),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .apb(apb),
    .core_busy(core_busy),
    .core_status(core_status),
    .regs(regs),
    .start(start)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] m_regs [NR];
  bit m_pend;
  int exp_starts = 0;
  int n_starts = 0;
  int n_double = 0;
  bit start_prev = 0;
  logic [NR*DW-1:0] regs_at_ready;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
    return f;
  endfunction

  always @(negedge clk) begin
    if (start === 1'b1) begin
      n_starts++;
      if (start_prev) n_double++;
    end
    start_prev = (start === 1'b1);
  end

  task automatic xfer(input bit wr,
                      input logic [19:0] addr,
                      input logic [31:0] wd,
                      input logic [3:0] sb,
                      output logic [31:0] rd,
                      output logic se);
    logic [7:0] off;
    int idx;
    int cyc;
    bit got;
    bit e;
    logic [31:0] erd;
    off = addr[7:0];
    idx = int'(off) / 4;
    e = (off[1:0] != 2'b00) || (idx > NR) ||
        (wr && idx == NR) || (wr && idx == 0 && m_pend);
    erd = '0;
    if (!wr && !e) begin
      if (idx == NR) erd = {core_status, m_pend, core_busy};
      else erd = m_regs[idx];
    end
    apb.PSEL = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE = wr;
    apb.PADDR = addr;
    apb.PWDATA = wd;
    apb.PSTRB = sb;
    @(posedge clk);
    #1 apb.PENABLE = 1'b1;
    cyc = 0;
    got = 0;
    rd = '0;
    se = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (apb.PREADY === 1'b1) begin
        got = 1;
        rd = apb.PRDATA;
        se = apb.PSLVERR;
        regs_at_ready = regs;
      end
      @(posedge clk);
      #1;
    end
    apb.PSEL = 1'b0;
    apb.PENABLE = 1'b0;
    chk("ready_seen", got, 1);
    chk("ready_cycle", cyc, WS + 1);
    chk("pslverr", se, e);
    chk("prdata", rd, erd);
    if (got && wr && !e && idx < NR) begin
      for (int b = 0; b < 4; b++)
        if (sb[b]) m_regs[idx][8*b +: 8] = wd[8*b +: 8];
      if (idx == 0 && sb != 0) begin
        if (core_busy) m_pend = 1;
        else exp_starts++;
      end
    end
    chk("regs", regs, m_flat());
  endtask

  logic [31:0] rd;
  logic se;
  logic [NR*DW-1:0] snap;

  initial begin
    rst = 1'b1;
    core_busy = 1'b0;
    core_status = '0;
    apb.PSEL = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE = 1'b0;
    apb.PADDR = '0;
    apb.PWDATA = '0;
    apb.PSTRB = '0;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_pend = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pready", apb.PREADY, 0);
    chk("rst_pslverr", apb.PSLVERR, 0);
    chk("rst_prdata", apb.PRDATA, 0);
    chk("rst_regs", regs, 0);
    chk("rst_start", start, 0);
    @(posedge clk);
    #1;

    for (int a = 0; a < 16; a += 4) begin
      xfer(0, 20'(a), '0, '0, rd, se);
      chk("rd_zero", rd, 0);
    end
    core_status = 30'd5;
    core_busy = 1'b1;
    xfer(0, 20'h10, '0, '0, rd, se);
    chk("status_rd", rd, 32'h15);
    core_busy = 1'b0;

    xfer(1, 20'h04, 32'hA5A5_1234, 4'hF, rd, se);
    chk("reg1_before", regs_at_ready[63:32], 0);
    chk("reg1_after", regs[63:32], 32'hA5A5_1234);
    xfer(0, 20'h04, '0, '0, rd, se);
    chk("reg1_rd", rd, 32'hA5A5_1234);

    xfer(1, 20'h08, 32'h1122_3344, 4'hF, rd, se);
    xfer(1, 20'h08, 32'hFFFF_FFFF, 4'b0101, rd, se);
    xfer(0, 20'h08, '0, '0, rd, se);
    chk("strb_rd", rd, 32'h11FF_33FF);

    snap = regs;
    xfer(1, 20'h10, 32'hDEAD_BEEF, 4'hF, rd, se);
    chk("err_wr_status", se, 1);
    xfer(1, 20'h06, 32'hDEAD_BEEF, 4'hF, rd, se);
    chk("err_misalign", se, 1);
    xfer(0, 20'h14, '0, '0, rd, se);
    chk("err_rd_oob", se, 1);
    chk("err_rd_data", rd, 0);
    chk("err_no_change", regs, snap);

    apb.PSEL = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE = 1'b1;
    apb.PADDR = 20'h0C;
    apb.PWDATA = 32'hDEAD_0001;
    apb.PSTRB = 4'hF;
    @(posedge clk);
    #1 apb.PENABLE = 1'b1;
    @(posedge clk);
    #1 apb.PSEL = 1'b0;
    apb.PENABLE = 1'b0;
    @(posedge clk);
    #1;
    xfer(0, 20'h0C, '0, '0, rd, se);
    chk("abort_rd", rd, 0);

    xfer(1, 20'h00, 32'h1, 4'hF, rd, se);
    @(negedge clk);
    chk("start_hi", start, 1);
    @(negedge clk);
    chk("start_lo", start, 0);

    @(posedge clk);
    #1 core_busy = 1'b1;
    xfer(1, 20'h00, 32'h3, 4'hF, rd, se);
    @(negedge clk);
    chk("pend_no_start", start, 0);
    xfer(0, 20'h10, '0, '0, rd, se);
    chk("pend_bit", rd[1], 1);
    xfer(1, 20'h00, 32'h7, 4'hF, rd, se);
    chk("pend_ctrl_err", se, 1);
    repeat (2) begin
      @(negedge clk);
      chk("busy_no_start", start, 0);
    end
    @(posedge clk);
    #1 core_busy = 1'b0;
    @(negedge clk);
    chk("rel_wait", start, 0);
    @(negedge clk);
    chk("rel_start", start, 1);
    m_pend = 0;
    exp_starts++;
    @(negedge clk);
    chk("rel_end", start, 0);
    xfer(0, 20'h10, '0, '0, rd, se);
    chk("pend_clear", rd[1], 0);

    for (int n = 0; n < 150; n++) begin
      logic [7:0] off;
      logic [19:0] addr;
      if ($urandom_range(0, 7) < 6) off = 8'($urandom_range(0, 5) * 4);
      else off = 8'($urandom_range(0, 255));
      addr = {12'($urandom), off};
      core_status = 30'($urandom);
      xfer(bit'($urandom_range(0, 1)), addr, $urandom,
           4'($urandom), rd, se);
    end

    apb.PSEL = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE = 1'b1;
    apb.PADDR = 20'h08;
    apb.PWDATA = 32'hCAFE_F00D;
    apb.PSTRB = 4'hF;
    @(posedge clk);
    #1 apb.PENABLE = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_pready", apb.PREADY, 0);
    chk("mid_rst_regs", regs, 0);
    chk("mid_rst_start", start, 0);
    apb.PSEL = 1'b0;
    apb.PENABLE = 1'b0;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_pend = 0;
    @(posedge clk);
    #1;
    xfer(0, 20'h08, '0, '0, rd, se);
    chk("mid_rst_rd", rd, 0);

    repeat (3) @(posedge clk);
    chk("start_count", n_starts, exp_starts);
    chk("start_width", n_double, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

Parametrised APB slave register file that generalises the encoder's fixed four-register configuration bus. It offers NUM_REGS read/write configuration words plus one read-only STATUS word, and supports PREADY wait states, PSLVERR, PSTRB byte strobes and a start handshake that defers while the core is busy. It sits between the APB fabric and the coding core: the core reads `regs` and `start`, and reports `core_busy` and `core_status`.

## Interface
- AMBA_WORD, 32: data width in bits; must be a multiple of 8.
- AMBA_ADDR_WIDTH, 20: PADDR width.
- NUM_REGS, 4: number of RW registers, 1..63. Index 0 is CTRL.
- WAIT_STATES, 0: extra ACCESS cycles before PREADY, 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  AMBA_ADDR_WIDTH  byte address. Only [7:0] is decoded.
- PWDATA  in  AMBA_WORD  write data.
- PSTRB  in  AMBA_WORD/8  byte-lane write strobes.
- PRDATA  out  AMBA_WORD  read data.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response; valid only while PREADY=1.
- core_busy  in  1  core is processing.
- core_status  in  AMBA_WORD-2  core status bits.
- regs  out  NUM_REGS*AMBA_WORD  flattened RW registers; register i occupies bits [i*AMBA_WORD +: AMBA_WORD].
- start  out  1  single-cycle start pulse to the core.

## Operation
- Address map:
  - offset = PADDR[7:0]; idx = offset>>2.
  - idx 0..NUM_REGS-1 are the RW registers.
  - idx NUM_REGS is STATUS, read-only, value {core_status, start_pending, core_busy}.
- Wait counter:
  - wait_cnt increments each cycle with PSEL&PENABLE&!PREADY.
  - It clears to 0 on any cycle without PSEL&PENABLE, and on completion.
  - PREADY = PSEL & PENABLE & (wait_cnt == WAIT_STATES), combinational.
- Completion: a transfer completes at the edge where PSEL&PENABLE&PREADY=1.
- Error conditions (err), evaluated at completion:
  - offset[1:0] != 0;
  - idx > NUM_REGS;
  - a write to STATUS;
  - a CTRL write while start_pending=1.
- Error response: PSLVERR = PREADY & err. An erroring transfer has no side effects: no register write, no start change.
- Writes:
  - On a non-error write completion, byte b of register idx takes PWDATA byte b where PSTRB[b]=1.
  - Other bytes hold.
  - The new value appears on `regs` the cycle after completion.
- Reads:
  - PRDATA is the addressed value while PREADY & !PWRITE & !err. It is 0 otherwise, including on an error read.
  - Reads have no side effects.
- Start handshake (registers start and start_pending):
  - ctrl_commit = non-error CTRL write completion with PSTRB nonzero.
  - start <= !core_busy & (ctrl_commit | start_pending).
  - start_pending <= core_busy & (ctrl_commit | start_pending).
  - Result: start is always a single-cycle pulse, and at most one start is ever pending.
- Setup phase (PSEL&!PENABLE) and idle (PSEL=0) cause no action.

## Timing
- Reset (rst=1 at an edge): all RW registers, start, start_pending and wait_cnt go to 0. PRDATA, PREADY and PSLVERR then read 0. Any in-flight transfer is abandoned with no write.
- Transfer length:
  - WAIT_STATES=0: two cycles (setup, access), PREADY=1 in the first access cycle.
  - Otherwise PREADY rises after WAIT_STATES access cycles, for 2+WAIT_STATES cycles in total.
- Back-to-back transfers are supported: wait_cnt clears on completion, so the next transfer's wait count starts from 0.
- CTRL write with core_busy=0 at the commit edge: start=1 exactly one cycle after the completion edge.
- CTRL write with core_busy=1: start_pending=1 the next cycle. start pulses one cycle after the first edge at which core_busy=0. Pending clears at that same edge.
- PSEL dropped mid-access before PREADY: wait_cnt clears and nothing is committed.

## Test plan
- Reset, then read offsets 0x00..0x0C → PRDATA=0, PSLVERR=0. Read 0x10 with core_status=5, core_busy=1 → PRDATA=0x15.
- WAIT_STATES=2: write 0xA5A5_1234 to offset 0x04 → PREADY only in the 3rd access cycle. Readback equals 0xA5A5_1234, and regs[63:32] updates the cycle after completion.
- PSTRB=4'b0101, write 0xFFFF_FFFF over 0x1122_3344 → readback 0x11FF_33FF.
- Errors: write to 0x10, write to 0x06, read at 0x14 → PSLVERR=1 with PREADY, PRDATA=0, and no register changes.
- CTRL write with core_busy=0 → start pulses for 1 cycle at T+1. CTRL write with core_busy=1 held 5 cycles → start_pending=1 and a second CTRL write gets PSLVERR. start pulses once, 1 cycle after core_busy falls.
- Assert rst during an access phase of a write to 0x08 → register stays 0, start=0, and PREADY=0 next cycle.
